// File: rtl/uart_rpt_ctrl.sv
// uart_rpt_ctrl: schedules periodic/event status frames onto one UART transmitter with snapshot and idle gap
module uart_rpt_ctrl #(
  parameter int unsigned PERIOD_CLKS = 4_000_000,
  parameter int unsigned FRAME_CLKS  = 829_233,
  parameter int unsigned GAP_CLKS    = 4167
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_en,
  input  logic       i_evt_req,
  input  logic       i_ovr_clr,
  input  logic [7:0] i_reg_1,
  input  logic [7:0] i_reg_2,
  input  logic [7:0] i_reg_3,
  input  logic [7:0] i_reg_4,
  input  logic [7:0] i_reg_5,
  input  logic [7:0] i_reg_6,
  output logic       o_tx_en,
  output logic [7:0] o_reg_1,
  output logic [7:0] o_reg_2,
  output logic [7:0] o_reg_3,
  output logic [7:0] o_reg_4,
  output logic [7:0] o_reg_5,
  output logic [7:0] o_reg_6,
  output logic       o_evt_ack,
  output logic       o_frame_done,
  output logic       o_busy,
  output logic       o_overrun
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state;
  logic [23:0] per_cnt, frm_cnt;
  logic per_pend, evt_pend, wrap, start;
  always_comb begin
    wrap  = i_en && per_cnt == 24'(PERIOD_CLKS - 1);
    start = state == IDLE && i_en && (per_pend || evt_pend);
  end
  // one counter serves both the frame and the gap; it restarts at each state change
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state        <= IDLE;
      per_cnt      <= '0;
      frm_cnt      <= '0;
      per_pend     <= 1'b0;
      evt_pend     <= 1'b0;
      o_tx_en      <= 1'b0;
      o_evt_ack    <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
      o_overrun    <= 1'b0;
      o_reg_1      <= '0;
      o_reg_2      <= '0;
      o_reg_3      <= '0;
      o_reg_4      <= '0;
      o_reg_5      <= '0;
      o_reg_6      <= '0;
    end else begin
      per_cnt      <= (!i_en || wrap) ? '0 : per_cnt + 24'd1;
      per_pend     <= wrap || (per_pend && !start);
      evt_pend     <= i_evt_req || (evt_pend && !start);
      o_overrun    <= (wrap && per_pend) || (o_overrun && !i_ovr_clr);
      o_evt_ack    <= start && evt_pend;
      o_frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= SEND;
          o_tx_en <= 1'b1;
          o_busy  <= 1'b1;
          frm_cnt <= '0;
          o_reg_1 <= i_reg_1;
          o_reg_2 <= i_reg_2;
          o_reg_3 <= i_reg_3;
          o_reg_4 <= i_reg_4;
          o_reg_5 <= i_reg_5;
          o_reg_6 <= i_reg_6;
        end
        SEND: if (!i_en || frm_cnt == 24'(FRAME_CLKS - 1)) begin
          state        <= GAP;
          o_tx_en      <= 1'b0;
          o_frame_done <= i_en;
          frm_cnt      <= '0;
        end else begin
          frm_cnt <= frm_cnt + 24'd1;
        end
        GAP: if (frm_cnt == 24'(GAP_CLKS - 1)) begin
          state   <= IDLE;
          o_busy  <= 1'b0;
          frm_cnt <= '0;
        end else begin
          frm_cnt <= frm_cnt + 24'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_rpt_ctrl.md
# uart_rpt_ctrl

Report scheduler for the 18-byte ASCII status-line UART transmitter. Decides when a status frame is sent: a periodic timer and a one-shot event requester share the single transmitter. The block snapshots the six status bytes so they stay stable for the whole frame. It drives the transmitter's enable for exactly one frame and then enforces an idle gap.

## Interface
- PERIOD_CLKS, 4_000_000: periodic report interval in clocks (100 ms at 40 MHz); 2..2^24-1.
- FRAME_CLKS, 829_233: enable-high time per frame, equal to 199 baud periods of 4167 clk (18 bytes × 11 periods + 1); 1..2^24-1.
- GAP_CLKS, 4167: minimum enable-low time between frames; 1..2^24-1.
- i_clk, in, 1: 40 MHz system clock.
- i_res, in, 1: reset, synchronous, active-high.
- i_en, in, 1: reporting enable; low stops the timer and aborts any frame.
- i_evt_req, in, 1: single-cycle request for an immediate report.
- i_ovr_clr, in, 1: clears o_overrun.
- i_reg_1..i_reg_6, in, 8 each: live status bytes.
- o_tx_en, out, 1: enable to the transmitter.
- o_reg_1..o_reg_6, out, 8 each: snapshot bytes to the transmitter.
- o_evt_ack, out, 1: one-cycle pulse when a frame serving an event starts.
- o_frame_done, out, 1: one-cycle pulse when a frame completes normally.
- o_busy, out, 1: high when the state is not IDLE.
- o_overrun, out, 1: sticky flag; a periodic request arrived while one was already pending.

## Operation
- **Reset values:** state IDLE; all counters 0; per_pend and evt_pend 0; all outputs 0.
- **Period timer (24 bit):**
  - Increments every cycle while i_en=1 and is held at 0 while i_en=0.
  - At PERIOD_CLKS-1 it wraps to 0 and sets per_pend.
  - If per_pend is already 1 at the wrap, o_overrun is set.
- **Event latch:** i_evt_req=1 sets evt_pend in any state. Requests stay pending across SEND and GAP.
- **IDLE:**
  - Exits when i_en=1 and (per_pend | evt_pend).
  - Exit actions: go to SEND; o_tx_en<=1; o_reg_n<=i_reg_n; frame counter<=0.
  - Both pending flags clear, because one frame serves both.
  - o_evt_ack pulses if evt_pend was 1.
- **SEND:**
  - The frame counter increments each cycle.
  - When the counter reaches FRAME_CLKS-1: go to GAP, o_tx_en<=0, o_frame_done pulses.
- **Abort:** i_en=0 in SEND forces GAP with o_tx_en<=0 and no o_frame_done. The transmitter resets itself on enable low.
- **GAP:** The counter runs from 0; at GAP_CLKS-1 the state goes to IDLE.
- **i_en in other states:** i_en=0 in GAP or IDLE does not alter the gap. Pending flags are kept, and are served once i_en returns.
- **Set/clear priority:** set wins. A timer wrap or i_evt_req in the same cycle as the IDLE→SEND clear leaves that flag set.
- **Overrun priority:** the o_overrun set wins over i_ovr_clr.
- **Snapshot:** o_reg_n changes only on the IDLE→SEND edge and holds between frames.
- **i_res:** overrides everything on the next edge. This includes mid-frame, where o_tx_en drops in that cycle.

## Timing
- All outputs are registered. o_tx_en rises one clock after the edge where the request flag is seen in IDLE with i_en=1.
- Example: a flag set at edge N gives o_tx_en=1 after edge N+1.
- o_tx_en stays high exactly FRAME_CLKS cycles, then low for at least GAP_CLKS cycles.
- o_evt_ack is coincident with the first o_tx_en=1 cycle. o_frame_done is coincident with the first o_tx_en=0 cycle.
- Minimum frame-start spacing is FRAME_CLKS+GAP_CLKS+1 cycles. With defaults, 100 ms periodic reports never overrun.

## Test plan
- **Periodic:** PERIOD_CLKS=100, FRAME_CLKS=20, GAP_CLKS=5; i_en=1 after reset → o_tx_en high for exactly 20 cycles, starting 101 cycles after i_en rise, then every 100 cycles; o_frame_done once per frame; o_overrun=0.
- **Snapshot hold:** i_reg_1=0x3C at frame start, changed to 0xA5 mid-frame → o_reg_1 stays 0x3C until the next frame start, then becomes 0xA5.
- **Event during SEND:** pulse i_evt_req mid-frame → no change to the current frame. A new frame starts one cycle after GAP ends (5 cycles low), with o_evt_ack pulsing on its first cycle.
- **Overrun:** PERIOD_CLKS=10, FRAME_CLKS=20 → o_overrun sets at the second wrap inside SEND. Assert i_ovr_clr on a non-wrap cycle → 0; assert it on a wrap cycle with per_pend=1 → stays 1.
- **Abort:** drop i_en at frame cycle 7 → o_tx_en low next cycle; no o_frame_done; o_busy high for 5 gap cycles; timer at 0; after i_en returns, the next frame starts 101 cycles later.
- **Reset mid-frame:** assert i_res during SEND → after the edge, all outputs 0 and state IDLE; a pending event is discarded.
